muldiv_unit: RTL and testbench

//  Iterative multiply/divide unit owning the HI/LO registers for MULT, MULTU, DIV, DIVU, MTHI, MTLO.

---
 rtl/muldiv_if.sv | 28 ++
 rtl/muldiv_unit.sv | 162 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_if.sv
// Bus between the pipeline controller and the iterative multiply/divide unit.
// Handshake: start, we_hi and we_lo are sampled on a rising edge only while busy=0;
// done is a one-cycle pulse issued when hi/lo have just been loaded with a result.
interface muldiv_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             we_hi;
   logic             we_lo;
   logic [WIDTH-1:0] wd;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, a, b, we_hi, we_lo, wd,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, op, a, b, we_hi, we_lo, wd,
      output busy, done, hi, lo
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; fixed WIDTH+1 cycle latency.
// Operates on magnitudes (shift-add / restoring divide) and applies signs in FIX.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic       clk,
   input  logic       reset_n,
   muldiv_if.slave    bus,
   output logic [1:0] dbg_state
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [1:0]         op_q, op_d;
   logic               neg_q, neg_d;
   logic               a_neg_q, a_neg_d;
   logic [WIDTH-1:0]   a_orig_q, a_orig_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [CW-1:0]      count_q, count_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               done_q, done_d;

   // Operand decode: op[0]=0 means signed, op[1]=1 means divide.
   logic             in_signed;
   logic             in_a_neg;
   logic             in_b_neg;
   logic [WIDTH-1:0] in_mag_a;
   logic [WIDTH-1:0] in_mag_b;

   assign in_signed = ~bus.op[0];
   assign in_a_neg  = in_signed & bus.a[WIDTH-1];
   assign in_b_neg  = in_signed & bus.b[WIDTH-1];
   assign in_mag_a  = in_a_neg ? -bus.a : bus.a;
   assign in_mag_b  = in_b_neg ? -bus.b : bus.b;

   // Multiply step: acc = {partial upper, remaining multiplier bits}.
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;

   assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
   assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

   // Divide step: acc = {partial remainder, dividend/quotient shift register}.
   logic [WIDTH:0]     div_shift;
   logic [WIDTH:0]     div_diff;
   logic               div_geq;
   logic [WIDTH-1:0]   div_rem;
   logic [2*WIDTH-1:0] div_next;

   assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
   assign div_diff  = div_shift - {1'b0, opnd_q};
   assign div_geq   = div_shift >= {1'b0, opnd_q};
   assign div_rem   = div_geq ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
   assign div_next  = {div_rem, acc_q[WIDTH-2:0], div_geq};

   // Sign correction of the finished magnitudes.
   logic               fix_signed;
   logic [2*WIDTH-1:0] fix_prod;
   logic [WIDTH-1:0]   fix_quo;
   logic [WIDTH-1:0]   fix_rem;

   assign fix_signed = ~op_q[0];
   assign fix_prod   = (fix_signed & neg_q) ? -acc_q : acc_q;
   assign fix_quo    = (fix_signed & neg_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
   assign fix_rem    = (fix_signed & a_neg_q) ? -acc_q[2*WIDTH-1:WIDTH]
                                               : acc_q[2*WIDTH-1:WIDTH];

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      neg_d    = neg_q;
      a_neg_d  = a_neg_q;
      a_orig_d = a_orig_q;
      opnd_d   = opnd_q;
      acc_d    = acc_q;
      count_d  = count_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      done_d   = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (bus.we_hi) hi_d = bus.wd;
            if (bus.we_lo) lo_d = bus.wd;
            if (bus.start) begin
               op_d     = bus.op;
               neg_d    = in_a_neg ^ in_b_neg;
               a_neg_d  = in_a_neg;
               a_orig_d = bus.a;
               opnd_d   = bus.op[1] ? in_mag_b : in_mag_a;
               acc_d    = {{WIDTH{1'b0}}, (bus.op[1] ? in_mag_a : in_mag_b)};
               count_d  = '0;
               state_d  = S_RUN;
            end
         end
         S_RUN: begin
            acc_d   = op_q[1] ? div_next : mul_next;
            count_d = count_q + 1'b1;
            if (count_q == CW'(WIDTH - 1)) state_d = S_FIX;
         end
         S_FIX: begin
            if (!op_q[1]) begin
               hi_d = fix_prod[2*WIDTH-1:WIDTH];
               lo_d = fix_prod[WIDTH-1:0];
            end else if (opnd_q == '0) begin
               hi_d = a_orig_q;
               lo_d = '1;
            end else begin
               hi_d = fix_rem;
               lo_d = fix_quo;
            end
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         op_q     <= '0;
         neg_q    <= 1'b0;
         a_neg_q  <= 1'b0;
         a_orig_q <= '0;
         opnd_q   <= '0;
         acc_q    <= '0;
         count_q  <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         neg_q    <= neg_d;
         a_neg_q  <= a_neg_d;
         a_orig_q <= a_orig_d;
         opnd_q   <= opnd_d;
         acc_q    <= acc_d;
         count_q  <= count_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         done_q   <= done_d;
      end
   end

   assign bus.busy  = (state_q != S_IDLE);
   assign bus.done  = done_q;
   assign bus.hi    = hi_q;
   assign bus.lo    = lo_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus randomized ops
// compared against a plain-arithmetic model of MULT/MULTU/DIV/DIVU.
module tb_muldiv_unit;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [1:0] dbg_state;
   int         n_checks = 0;
   int         n_pass = 0;
   logic [63:0] exp_q[$];

   muldiv_if #(.WIDTH(32)) bus ();

   muldiv_unit #(.WIDTH(32)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   // {hi, lo} expected for one operation.
   function automatic logic [63:0] ref_muldiv(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
      longint      sa, sb, q, r;
      logic [63:0] ua, ub;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'b0, a};
      ub = {32'b0, b};
      case (op)
         2'b00: return 64'(sa * sb);
         2'b01: return ua * ub;
         2'b10: begin
            if (b == 32'b0) return {a, 32'hFFFF_FFFF};
            q = sa / sb;
            r = sa % sb;
            return {32'(r), 32'(q)};
         end
         default: begin
            if (b == 32'b0) return {a, 32'hFFFF_FFFF};
            return {32'(ua % ub), 32'(ua / ub)};
         end
      endcase
   endfunction

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 7))
         0: return 32'h0000_0000;
         1: return 32'h0000_0001;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         5: return 32'($urandom_range(0, 255));
         default: return $urandom;
      endcase
   endfunction

   // Launch one op and watch it; tail = cycles to keep watching after done.
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int tail, output int lat, output int busy_cnt,
                         output int done_cnt, output logic [31:0] hi_o,
                         output logic [31:0] lo_o, output bit held);
      logic [31:0] hi0, lo0;
      @(negedge clk);
      hi0 = bus.hi;
      lo0 = bus.lo;
      bus.start = 1'b1;
      bus.op = op;
      bus.a = a;
      bus.b = b;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      lat = -1;
      busy_cnt = 0;
      done_cnt = 0;
      held = 1'b1;
      hi_o = 'x;
      lo_o = 'x;
      if (bus.busy) busy_cnt++;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         #1;
         if (bus.busy) busy_cnt++;
         if (bus.done) begin
            done_cnt++;
            if (lat < 0) begin
               lat = k;
               hi_o = bus.hi;
               lo_o = bus.lo;
            end
         end else if (lat < 0 && (bus.hi !== hi0 || bus.lo !== lo0)) begin
            held = 1'b0;
         end
         if (lat >= 0 && k >= lat + tail) break;
      end
   endtask

   task automatic test_reset();
      n_checks++;
      if (bus.hi !== 32'h0) $display("FAIL reset_hi: got %h want 0", bus.hi); else n_pass++;
      n_checks++;
      if (bus.lo !== 32'h0) $display("FAIL reset_lo: got %h want 0", bus.lo); else n_pass++;
      n_checks++;
      if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else n_pass++;
      n_checks++;
      if (bus.done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.done); else n_pass++;
      n_checks++;
      if (dbg_state !== 2'd0) $display("FAIL reset_state: got %0d want 0", dbg_state); else n_pass++;
   endtask

   task automatic check_vectors(input string tag, input logic [1:0] ops[], input logic [31:0] as[],
                                input logic [31:0] bs[]);
      int lat, busy_cnt, done_cnt;
      logic [31:0] hi_o, lo_o;
      logic [63:0] exp;
      bit held;
      foreach (ops[i]) begin
         exp = ref_muldiv(ops[i], as[i], bs[i]);
         run_op(ops[i], as[i], bs[i], 3, lat, busy_cnt, done_cnt, hi_o, lo_o, held);
         n_checks++;
         if (lat !== 33) $display("FAIL %s_latency[%0d]: got %0d want 33", tag, i, lat); else n_pass++;
         n_checks++;
         if (busy_cnt !== 33) $display("FAIL %s_busy_cycles[%0d]: got %0d want 33", tag, i, busy_cnt);
         else n_pass++;
         n_checks++;
         if (done_cnt !== 1) $display("FAIL %s_done_pulses[%0d]: got %0d want 1", tag, i, done_cnt);
         else n_pass++;
         n_checks++;
         if ({hi_o, lo_o} !== exp)
            $display("FAIL %s_result[%0d] op=%0d a=%h b=%h: got %h_%h want %h_%h", tag, i, ops[i],
                     as[i], bs[i], hi_o, lo_o, exp[63:32], exp[31:0]);
         else n_pass++;
         n_checks++;
         if (!held) $display("FAIL %s_hold[%0d]: hi/lo changed before done", tag, i); else n_pass++;
      end
   endtask

   task automatic test_mul();
      logic [1:0]  ops[] = new[13];
      logic [31:0] as[] = new[13];
      logic [31:0] bs[] = new[13];
      ops[0] = 2'b01; as[0] = 32'hFFFF_FFFF; bs[0] = 32'hFFFF_FFFF;
      ops[1] = 2'b00; as[1] = -32'sd3;       bs[1] = 32'd7;
      ops[2] = 2'b00; as[2] = 32'h8000_0000; bs[2] = 32'h8000_0000;
      for (int i = 3; i < 13; i++) begin
         ops[i] = 2'($urandom_range(0, 1));
         as[i] = pick_operand();
         bs[i] = pick_operand();
      end
      check_vectors("mul", ops, as, bs);
   endtask

   task automatic test_div();
      logic [1:0]  ops[] = new[15];
      logic [31:0] as[] = new[15];
      logic [31:0] bs[] = new[15];
      ops[0] = 2'b10; as[0] = -32'sd7;       bs[0] = 32'd2;
      ops[1] = 2'b11; as[1] = 32'd7;         bs[1] = 32'd2;
      ops[2] = 2'b11; as[2] = 32'd100;       bs[2] = 32'd0;
      ops[3] = 2'b10; as[3] = 32'h8000_0000; bs[3] = 32'hFFFF_FFFF;
      ops[4] = 2'b10; as[4] = -32'sd5;       bs[4] = 32'd0;
      for (int i = 5; i < 15; i++) begin
         ops[i] = 2'($urandom_range(2, 3));
         as[i] = pick_operand();
         bs[i] = pick_operand();
      end
      check_vectors("div", ops, as, bs);
   endtask

   task automatic test_busy_ignore();
      logic [31:0] hi0, lo0, hi_o, lo_o;
      int lat, done_cnt;
      bit held;
      @(negedge clk);
      hi0 = bus.hi;
      lo0 = bus.lo;
      bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'd2; bus.b = 32'd3;
      @(posedge clk);
      lat = -1; done_cnt = 0; held = 1'b1; hi_o = 'x; lo_o = 'x;
      for (int k = 1; k <= 45; k++) begin
         @(negedge clk);
         bus.start = (k == 10);
         bus.we_lo = (k == 10);
         bus.we_hi = (k == 10);
         bus.wd = 32'h1234;
         bus.op = (k == 10) ? 2'b10 : 2'b01;
         bus.a = (k == 10) ? 32'd99 : 32'd2;
         @(posedge clk);
         #1;
         if (bus.done) begin
            done_cnt++;
            if (lat < 0) begin lat = k; hi_o = bus.hi; lo_o = bus.lo; end
         end else if (lat < 0 && (bus.hi !== hi0 || bus.lo !== lo0)) begin
            held = 1'b0;
         end
      end
      bus.start = 1'b0; bus.we_lo = 1'b0; bus.we_hi = 1'b0;
      n_checks++;
      if (lat !== 33) $display("FAIL busy_ignore_latency: got %0d want 33", lat); else n_pass++;
      n_checks++;
      if (done_cnt !== 1) $display("FAIL busy_ignore_done_pulses: got %0d want 1", done_cnt); else n_pass++;
      n_checks++;
      if ({hi_o, lo_o} !== 64'd6) $display("FAIL busy_ignore_result: got %h_%h want 0_6", hi_o, lo_o);
      else n_pass++;
      n_checks++;
      if (!held) $display("FAIL busy_ignore_hold: hi/lo written while busy"); else n_pass++;
   endtask

   task automatic test_mthi_mtlo();
      logic [31:0] lo0, hi0;
      int lat;
      @(negedge clk);
      lo0 = bus.lo;
      bus.we_hi = 1'b1; bus.wd = 32'h55;
      @(posedge clk); #1;
      bus.we_hi = 1'b0;
      n_checks++;
      if (bus.hi !== 32'h55 || bus.lo !== lo0)
         $display("FAIL mthi: got hi=%h lo=%h want hi=55 lo=%h", bus.hi, bus.lo, lo0);
      else n_pass++;
      @(negedge clk);
      hi0 = bus.hi;
      bus.we_lo = 1'b1; bus.wd = 32'hCAFE_0001;
      @(posedge clk); #1;
      bus.we_lo = 1'b0;
      n_checks++;
      if (bus.lo !== 32'hCAFE_0001 || bus.hi !== hi0)
         $display("FAIL mtlo: got hi=%h lo=%h want hi=%h lo=cafe0001", bus.hi, bus.lo, hi0);
      else n_pass++;
      @(negedge clk);
      bus.we_hi = 1'b1; bus.we_lo = 1'b1; bus.wd = 32'hA5A5_5A5A;
      @(posedge clk); #1;
      bus.we_hi = 1'b0; bus.we_lo = 1'b0;
      n_checks++;
      if (bus.hi !== 32'hA5A5_5A5A || bus.lo !== 32'hA5A5_5A5A)
         $display("FAIL mthi_mtlo_both: got %h_%h want a5a55a5a_a5a55a5a", bus.hi, bus.lo);
      else n_pass++;
      // Write and launch in the same IDLE cycle.
      @(negedge clk);
      bus.we_hi = 1'b1; bus.wd = 32'hDEAD_BEEF;
      bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'd4; bus.b = 32'd5;
      @(posedge clk); #1;
      bus.we_hi = 1'b0; bus.start = 1'b0;
      n_checks++;
      if (bus.hi !== 32'hDEAD_BEEF || bus.busy !== 1'b1)
         $display("FAIL write_with_start: got hi=%h busy=%b want deadbeef 1", bus.hi, bus.busy);
      else n_pass++;
      lat = -1;
      for (int k = 1; k <= 40 && lat < 0; k++) begin
         @(posedge clk); #1;
         if (bus.done) lat = k;
      end
      n_checks++;
      if (lat !== 33 || bus.hi !== 32'd0 || bus.lo !== 32'd20)
         $display("FAIL write_with_start_result: got lat=%0d %h_%h want 33 0_14", lat, bus.hi, bus.lo);
      else n_pass++;
   endtask

   task automatic test_reset_abort();
      int done_cnt;
      bit stayed;
      @(negedge clk);
      bus.we_hi = 1'b1; bus.we_lo = 1'b1; bus.wd = 32'h1111_1111;
      @(negedge clk);
      bus.we_hi = 1'b0; bus.we_lo = 1'b0;
      bus.start = 1'b1; bus.op = 2'b11; bus.a = 32'd1000; bus.b = 32'd7;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (20) @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      n_checks++;
      if (bus.hi !== 32'h0 || bus.lo !== 32'h0 || bus.busy !== 1'b0 || bus.done !== 1'b0)
         $display("FAIL reset_abort: got hi=%h lo=%h busy=%b done=%b want 0 0 0 0", bus.hi, bus.lo,
                  bus.busy, bus.done);
      else n_pass++;
      @(negedge clk);
      reset_n = 1'b1;
      done_cnt = 0;
      stayed = 1'b1;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         if (bus.done) done_cnt++;
         if (bus.busy || bus.hi !== 32'h0 || bus.lo !== 32'h0) stayed = 1'b0;
      end
      n_checks++;
      if (done_cnt !== 0) $display("FAIL reset_abort_done: got %0d pulses want 0", done_cnt); else n_pass++;
      n_checks++;
      if (!stayed) $display("FAIL reset_abort_idle: got activity after abort want none"); else n_pass++;
      @(negedge clk);
      bus.we_hi = 1'b1; bus.wd = 32'h55;
      @(posedge clk); #1;
      bus.we_hi = 1'b0;
      n_checks++;
      if (bus.hi !== 32'h55 || bus.lo !== 32'h0)
         $display("FAIL reset_abort_mthi: got %h_%h want 55_0", bus.hi, bus.lo);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      int lat, busy_cnt, done_cnt;
      logic [31:0] hi_o, lo_o;
      logic [63:0] exp;
      logic [1:0]  op;
      logic [31:0] a, b;
      bit held;
      for (int i = 0; i < 12; i++) begin
         op = 2'($urandom_range(0, 3));
         a = pick_operand();
         b = pick_operand();
         exp_q.push_back(ref_muldiv(op, a, b));
         run_op(op, a, b, 0, lat, busy_cnt, done_cnt, hi_o, lo_o, held);
         exp = exp_q.pop_front();
         n_checks++;
         if (lat !== 33 || {hi_o, lo_o} !== exp)
            $display("FAIL b2b[%0d] op=%0d a=%h b=%h: got lat=%0d %h_%h want 33 %h_%h", i, op, a, b,
                     lat, hi_o, lo_o, exp[63:32], exp[31:0]);
         else n_pass++;
      end
   endtask

   initial begin
      reset_n = 1'b0;
      bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
      bus.we_hi = 1'b0; bus.we_lo = 1'b0; bus.wd = '0;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      @(negedge clk);
      reset_n = 1'b1;
      test_mul();
      test_div();
      test_busy_ignore();
      test_mthi_mtlo();
      test_reset_abort();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
